// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the IF1 fetch controller
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, used for the PC FIFO and instruction queue
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           clear,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy tracking; clear empties the FIFO like reset does.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; entries need no reset because occupancy gates their use.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_ctrl_if1.sv
// rtl/fetch_ctrl_if1.sv - IF1 fetch controller; FETCH_BYPASS_EN enables zero-latency response bypass
module fetch_ctrl_if1
   import fetch_pkg::*;
#(
   parameter int unsigned FQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] current_pc_if1,
   output logic [31:0] next_pc_if1,
   output logic        pc_en,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid_o,
   output logic [31:0] inst_data_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam int unsigned OW = $clog2(FQ_DEPTH + 1);
   localparam logic [OW:0] DEPTH_W = (OW + 1)'(FQ_DEPTH);

   fetch_state_e  state;
   fetch_state_e  state_n;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] drop;
   logic [OW-1:0] drop_redirect;
   logic [OW-1:0] q_count;
   logic [OW-1:0] pc_count;
   logic [OW:0]   inflight;
   logic          accept;
   logic          rsp_ok;
   logic          rsp_keep;
   logic          bypass_take;
   logic          q_empty;
   logic          q_push;
   logic          q_pop;
   logic [31:0]   pc_head;
   fq_entry_t     q_head;
   fq_entry_t     q_in;

   // A response with nothing in flight is ignored rather than underflowing the count.
   assign rsp_ok        = imem_rsp_valid && (outstanding != '0);
   // Only live responses in RUN outside a redirect cycle reach decode.
   assign rsp_keep      = rsp_ok && (state == RUN) && !redirect_valid;
   assign drop_redirect = outstanding - OW'(rsp_ok);
   assign inflight      = {1'b0, outstanding} + {1'b0, q_count};
   assign accept        = imem_req_valid && imem_req_ready;
   assign imem_req_addr = current_pc_if1;
   assign q_empty       = (q_count == '0);

`ifdef FETCH_BYPASS_EN
   assign bypass_take = rsp_keep && q_empty && inst_ready_i;
`else
   assign bypass_take = 1'b0;
`endif

   assign q_push  = rsp_keep && !bypass_take;
   assign q_pop   = inst_ready_i && !q_empty && !redirect_valid;
   assign q_in.pc   = pc_head;
   assign q_in.inst = imem_rsp_data;

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (FQ_DEPTH)
   ) u_pc_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (redirect_valid),
      .push      (accept),
      .push_data (current_pc_if1),
      .pop       (rsp_keep),
      .pop_data  (pc_head),
      .count     (pc_count)
   );

   fetch_fifo #(
      .WIDTH ($bits(fq_entry_t)),
      .DEPTH (FQ_DEPTH)
   ) u_inst_q (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (redirect_valid),
      .push      (q_push),
      .push_data (q_in),
      .pop       (q_pop),
      .pop_data  (q_head),
      .count     (q_count)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Next state: redirect wins; FLUSH ends on the response that empties drop.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = RUN;
         default: begin
            if (redirect_valid)
               state_n = (drop_redirect != '0) ? FLUSH : RUN;
            else if ((state == FLUSH) && rsp_ok && (drop == OW'(1)))
               state_n = RUN;
         end
      endcase
   end

   // Fetch request, PC enable and next PC.
   always_comb begin
      imem_req_valid = (state == RUN) && !redirect_valid && (inflight < DEPTH_W);
      pc_en          = redirect_valid || (imem_req_valid && imem_req_ready);
      next_pc_if1    = redirect_valid ? redirect_pc : current_pc_if1 + PC_INC;
   end

   // In-flight and stale-response counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding + OW'(accept) - OW'(rsp_ok);
         if (redirect_valid)
            drop <= drop_redirect;
         else if ((state == FLUSH) && rsp_ok)
            drop <= drop - OW'(1);
      end
   end

   // Decode-side outputs: queue head, or the live response when bypassing.
   always_comb begin
      inst_valid_o = !q_empty;
      inst_pc_o    = q_empty ? RESET_PC : q_head.pc;
      inst_data_o  = q_empty ? 32'd0 : q_head.inst;
      if (bypass_take) begin
         inst_valid_o = 1'b1;
         inst_pc_o    = pc_head;
         inst_data_o  = imem_rsp_data;
      end
   end

   // A response with nothing in flight is a memory-side protocol error.
   rsp_without_request: assert property (@(posedge clk) disable iff (!reset_n)
      !(imem_rsp_valid && (outstanding == '0)));

   // While running, every in-flight fetch has its PC recorded.
   pc_fifo_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
      (state == RUN) |-> (pc_count == outstanding));

endmodule
